bit_serializer_tx: RTL

- Parallel-to-serial stage directly upstream of the 1111001 sequence detectors.
- Accepts WIDTH-bit words over a valid/ready handshake and drives them onto the single-bit serial line `x`, one bit per clk.
- A one-word holding buffer lets back-to-back words stream with no idle gap, so patterns spanning word boundaries reach the detector intact.
- When no word is being shifted, the line carries a configurable idle bit.

---
 rtl/bit_serializer_tx.sv | 116 +++++++++++
 1 files changed

// File: rtl/bit_serializer_tx.sv
// Parallel-to-serial transmitter feeding the 1111001 sequence detectors.
// Words arrive over a valid/ready handshake and leave on x one bit per clock.
// A one-word holding buffer lets consecutive words stream with no idle gap.
module bit_serializer_tx #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1,
    parameter bit IDLE_BIT  = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             x,
    output logic             x_valid,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shifter_q, shifter_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic             hold_full_q, hold_full_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic             xfer;
    logic             head_bit;
    logic [WIDTH-1:0] shifted;

    // Head bit and the shifter after one bit has been sent, zero filled.
    always_comb begin
        head_bit = 1'b0;
        shifted  = '0;
        if (MSB_FIRST) begin
            head_bit = shifter_q[WIDTH-1];
            shifted  = {shifter_q[WIDTH-2:0], 1'b0};
        end else begin
            head_bit = shifter_q[0];
            shifted  = {1'b0, shifter_q[WIDTH-1:1]};
        end
    end

    // Register bank; reset discards any partially sent word and the buffer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            shifter_q   <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            shifter_q   <= shifter_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            cnt_q       <= cnt_d;
        end
    end

    // Next-state logic; the last bit of a word prefers the held word, then a
    // direct load of the incoming word, so word boundaries carry no gap.
    always_comb begin
        state_d     = state_q;
        shifter_d   = shifter_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        cnt_d       = cnt_q;
        in_ready    = !hold_full_q;
        xfer        = in_valid && !hold_full_q;
        x_valid     = (state_q == SHIFT);
        x           = (state_q == SHIFT) ? head_bit : IDLE_BIT;
        busy        = (state_q == SHIFT) || hold_full_q;

        case (state_q)
            IDLE: begin
                if (xfer) begin
                    shifter_d = in_data;
                    cnt_d     = CW'(WIDTH);
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt_q > CW'(1)) begin
                    shifter_d = shifted;
                    cnt_d     = cnt_q - CW'(1);
                    if (xfer) begin
                        hold_d      = in_data;
                        hold_full_d = 1'b1;
                    end
                end else if (hold_full_q) begin
                    shifter_d   = hold_q;
                    cnt_d       = CW'(WIDTH);
                    hold_full_d = 1'b0;
                end else if (xfer) begin
                    shifter_d = in_data;
                    cnt_d     = CW'(WIDTH);
                end else begin
                    shifter_d = '0;
                    cnt_d     = '0;
                    state_d   = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

endmodule
